uart_rx_sampler_mv: RTL and testbench
=====================================

Name: uart_rx_sampler_mv

Overview:
- Parametrised next-generation UART RX bit sampler.
- Synchronises the raw RX line, then takes NUM_SAMPLES consecutive oversamples centred on the bit midpoint and majority-votes them.
- Reports the bit with a one-cycle valid pulse, plus a noise flag when the samples disagree.
- Sits between the RX edge/bit counter and the RX FSM / deserializer / parity / stop checkers.

Parameters:
- PRESCALE_W, 8: width of prescale.
- CNT_W, 16: width of edge_count.
- NUM_SAMPLES, 3: samples per bit in majority mode; odd, 1..15.
- SYNC_STAGES, 2: input synchroniser depth; 0 = bypass.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- data  in  1  raw serial RX line.
- enable  in  1  sampling enable from RX FSM.
- edge_count  in  CNT_W  oversample edge counter within the current bit, +1 per clk, 0..prescale-1.
- prescale  in  PRESCALE_W  oversampling ratio.
- majority_en  in  1  1 = NUM_SAMPLES vote, 0 = single centre sample.
- sampled_data  out  1  voted bit value; held between valids.
- valid  out  1  one-cycle pulse: sampled_data/noise are new.
- noise  out  1  samples of the reported bit were not unanimous; qualified by valid.
- cfg_err  out  1  registered level: majority requested but prescale < NUM_SAMPLES+2.

Behaviour:
- Reset (async, rst=0): sampled_data=1 (line idle), valid=0, noise=0, cfg_err=0, state=IDLE, sample shift/ones counter/taken counter=0, synchroniser flops=1.
- Synchroniser: data_s = data delayed SYNC_STAGES clks. Only data_s is sampled.
- center = prescale>>1.
- n_eff:
  - NUM_SAMPLES if majority_en=1 and prescale >= NUM_SAMPLES+2.
  - Otherwise 1; cfg_err=1 when majority_en=1 and the prescale condition fails.
  - cfg_err updates every clk.
- Window: start = center - (n_eff-1)/2; end = start + n_eff - 1. Widths extended to CNT_W; no underflow is possible given the cfg_err rule.
- FSM states IDLE, COLLECT, REPORT (encoding in package):
  - IDLE: enable=1 and edge_count==start → capture data_s, taken=1, ones=data_s. Then REPORT if n_eff==1, else COLLECT.
  - COLLECT: enable=1 and edge_count==start+taken → capture, taken+1, ones+data_s. When the capture is at edge_count==end → REPORT.
  - COLLECT abort: any other edge_count (stall, jump back, wrap to 0, skip) or enable=0 → IDLE. Counters cleared, no valid, sampled_data/noise unchanged.
  - REPORT: single state, always → IDLE next clk. Drives registered outputs in this cycle:
    - valid=1.
    - sampled_data = (ones > (n_eff-1)/2).
    - noise = (ones != 0 and ones != n_eff).
- Latency: valid asserted exactly 1 clk after the clk where edge_count==end is sampled. It is never asserted in two consecutive clks.
- enable=0 in any state → IDLE next clk, valid=0. This takes priority over REPORT: a REPORT cycle with enable=0 emits no valid.
- majority_en/prescale are sampled every clk. Changing them mid-window is allowed: window bounds follow the new values and a mismatch aborts per the COLLECT rule.
- Reset mid-window: immediate return to reset values, no valid.
- ones/taken counters sized $clog2(NUM_SAMPLES+1).

Decomposition:
- Shared package (uart_pkg): FSM state encoding localparams; IDLE_LINE=1'b1 constant; PRESCALE_W/CNT_W defaults shared with the edge counter and RX FSM.
- One sub-module: sync_nff (parametrised N-stage synchroniser, reset value parameter, DEPTH=0 bypass), instantiated for data.

Test Plan:
- All scenarios use NUM_SAMPLES=3, SYNC_STAGES=0, prescale=8, enable=1 unless stated; edge_count free-runs 0..7.
- Nominal vote: majority_en=1, data=1 throughout → window 3..5; valid=1 exactly at clk after edge_count=5; sampled_data=1, noise=0; valid=0 elsewhere.
- Glitch: data_s=1,0,1 at edge_count 3,4,5 → sampled_data=1, noise=1. Then 0,0,1 → sampled_data=0, noise=1.
- Single mode: majority_en=0, data 0 only at edge_count=4 → one valid after edge_count=4, sampled_data=0, noise=0.
- Config error: prescale=4, majority_en=1 → cfg_err=1; single sample at edge_count=2; valid after it. prescale=5 → cfg_err=0, window 1..3.
- Aborts:
  - enable dropped at edge_count=4 → no valid; sampled_data keeps prior value.
  - edge_count jumps 4→0 mid-window → no valid; next full window 3..5 reports normally.
  - rst=0 at edge_count=4 → outputs at reset values immediately.
- Synchroniser: SYNC_STAGES=2, data steps 1→0 two clks before edge_count=3 → first sample still 1. Voted result is 1 for samples 1,0,0? No: 1,0,0 → sampled_data=0, noise=1, confirming 2-clk delay.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART RX definitions: sampler FSM encoding, idle line level and the
// default counter widths used by the edge counter, sampler and RX FSM.
package uart_pkg;

  localparam int PRESCALE_W_DEF = 8;
  localparam int CNT_W_DEF      = 16;

  localparam logic IDLE_LINE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } sampler_state_e;

endpackage

// File: rtl/sync_nff.sv
// N-stage flop synchroniser with a programmable reset level; DEPTH=0 is a
// straight wire for inputs that are already synchronous.
module sync_nff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_sync
    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= {DEPTH{RESET_VAL}};
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/uart_rx_sampler_mv.sv
// UART RX bit sampler: synchronises the line, collects a window of oversamples
// centred on the bit midpoint and reports the majority value with a noise flag.
module uart_rx_sampler_mv
  import uart_pkg::*;
#(
  parameter int PRESCALE_W  = PRESCALE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      edge_count,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  majority_en,
  output logic                  sampled_data,
  output logic                  valid,
  output logic                  noise,
  output logic                  cfg_err,
  output sampler_state_e        state_dbg
);

  localparam int SW = $clog2(NUM_SAMPLES + 1);
  localparam logic [PRESCALE_W:0] MIN_PRESCALE = (PRESCALE_W + 1)'(NUM_SAMPLES + 2);

  logic            data_s;
  sampler_state_e  state_q;
  logic [SW-1:0]   taken_q;
  logic [SW-1:0]   ones_q;
  logic            prescale_short;
  logic [SW-1:0]   n_eff;
  logic [CNT_W-1:0] win_start;
  logic [CNT_W-1:0] win_end;
  logic [CNT_W-1:0] next_ec;

  sync_nff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (IDLE_LINE)
  ) u_sync_data (
    .clk   (clk),
    .rst_n (rst),
    .d     (data),
    .q     (data_s)
  );

  // Window is recomputed every cycle so config changes take effect at once;
  // a window that no longer lines up with edge_count aborts in COLLECT.
  always_comb begin
    prescale_short = {1'b0, prescale} < MIN_PRESCALE;
    n_eff          = (majority_en && !prescale_short) ? SW'(NUM_SAMPLES) : SW'(1);
    win_start      = CNT_W'(prescale >> 1) - CNT_W'((n_eff - SW'(1)) >> 1);
    win_end        = win_start + CNT_W'(n_eff - SW'(1));
    next_ec        = win_start + CNT_W'(taken_q);
  end

  // Output protocol: valid is a one-cycle pulse and is the only qualifier;
  // sampled_data and noise hold their last reported values between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      taken_q      <= '0;
      ones_q       <= '0;
      sampled_data <= IDLE_LINE;
      valid        <= 1'b0;
      noise        <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= majority_en && prescale_short;
      valid   <= 1'b0;
      if (!enable) begin
        state_q <= ST_IDLE;
        taken_q <= '0;
        ones_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (edge_count == win_start) begin
              taken_q <= SW'(1);
              ones_q  <= SW'(data_s);
              state_q <= (n_eff == SW'(1)) ? ST_REPORT : ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (edge_count == next_ec) begin
              taken_q <= taken_q + SW'(1);
              ones_q  <= ones_q + SW'(data_s);
              if (edge_count == win_end) begin
                state_q <= ST_REPORT;
              end
            end else begin
              state_q <= ST_IDLE;
              taken_q <= '0;
              ones_q  <= '0;
            end
          end
          ST_REPORT: begin
            // Vote against the samples actually taken for this bit.
            valid        <= 1'b1;
            sampled_data <= ones_q > ((taken_q - SW'(1)) >> 1);
            noise        <= (ones_q != '0) && (ones_q != taken_q);
            state_q      <= ST_IDLE;
            taken_q      <= '0;
            ones_q       <= '0;
          end
          default: begin
            state_q <= ST_IDLE;
            taken_q <= '0;
            ones_q  <= '0;
          end
        endcase
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_sampler_mv.sv
// Bench for the UART RX majority sampler: two instances (no synchroniser and
// a 2-stage synchroniser) share stimulus and are checked against one model.
`timescale 1ns/1ps
module tb_uart_rx_sampler_mv;
  import uart_pkg::*;

  localparam int NS = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        data = 1'b1;
  logic        enable = 1'b0;
  logic        majority_en = 1'b1;
  logic [15:0] edge_count = '0;
  logic [7:0]  prescale = 8'd8;
  logic        sd0, v0, nz0, cfg0, sd2, v2, nz2, cfg2;
  sampler_state_e st0, st2;

  uart_rx_sampler_mv #(.PRESCALE_W(8), .CNT_W(16), .NUM_SAMPLES(NS), .SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .rst(rst), .data(data), .enable(enable), .edge_count(edge_count),
    .prescale(prescale), .majority_en(majority_en), .sampled_data(sd0), .valid(v0),
    .noise(nz0), .cfg_err(cfg0), .state_dbg(st0));

  uart_rx_sampler_mv #(.PRESCALE_W(8), .CNT_W(16), .NUM_SAMPLES(NS), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .data(data), .enable(enable), .edge_count(edge_count),
    .prescale(prescale), .majority_en(majority_en), .sampled_data(sd2), .valid(v2),
    .noise(nz2), .cfg_err(cfg2), .state_dbg(st2));

  int n_vec = 0;
  int n_err = 0;

  // reference model: raw-line history plus, per instance, the samples gathered so far
  bit          hist_q[$];
  int          got_m[2];
  logic [15:0] samp_m[2];
  bit          rep_m[2];
  logic        exp_v[2], exp_sd[2], exp_nz[2];
  logic        exp_cfg;

  wire [7:0] obs     = {v0, sd0, nz0, cfg0, v2, sd2, nz2, cfg2};
  wire [7:0] exp_vec = {exp_v[0], exp_sd[0], exp_nz[0], exp_cfg, exp_v[1], exp_sd[1], exp_nz[1], exp_cfg};

  task automatic model_reset();
    hist_q.delete();
    for (int i = 0; i < 3; i++) hist_q.push_back(1'b1);
    exp_cfg = 1'b0;
    for (int m = 0; m < 2; m++) begin
      got_m[m] = 0; rep_m[m] = 0; samp_m[m] = '0;
      exp_v[m] = 1'b0; exp_sd[m] = 1'b1; exp_nz[m] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int p, n, start, fin, ones, ec;
    bit ds;
    hist_q.push_front(data);
    while (hist_q.size() > 3) void'(hist_q.pop_back());
    p       = int'(prescale);
    ec      = int'(edge_count);
    exp_cfg = majority_en && (p < NS + 2);
    n       = (majority_en && p >= NS + 2) ? NS : 1;
    start   = p / 2 - (n - 1) / 2;
    fin     = start + n - 1;
    for (int m = 0; m < 2; m++) begin
      ds = hist_q[(m == 0) ? 0 : 2];
      exp_v[m] = 1'b0;
      if (!enable) begin
        got_m[m] = 0; rep_m[m] = 0;
      end else if (rep_m[m]) begin
        ones = 0;
        for (int i = 0; i < got_m[m]; i++) ones += int'(samp_m[m][i]);
        exp_v[m]  = 1'b1;
        exp_sd[m] = (2 * ones > got_m[m]);
        exp_nz[m] = (ones != 0) && (ones != got_m[m]);
        got_m[m] = 0; rep_m[m] = 0;
      end else if (got_m[m] == 0) begin
        if (ec == start) begin
          samp_m[m][0] = ds; got_m[m] = 1; rep_m[m] = (n == 1);
        end
      end else if (ec == start + got_m[m]) begin
        samp_m[m][got_m[m]] = ds; got_m[m]++; rep_m[m] = (ec == fin);
      end else begin
        got_m[m] = 0;
      end
    end
  endtask

  // driver: inputs change on the falling edge, outputs are checked 1ns after the rising edge
  task automatic cyc(input int ec, input bit d, input bit en);
    @(negedge clk);
    edge_count = 16'(ec); data = d; enable = en;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (obs !== 8'b0100_0100) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", obs, 8'b0100_0100); end
    n_vec++; if (st0 !== ST_IDLE || st2 !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d/%0d exp=%0d", st0, st2, ST_IDLE); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_nominal();
    prescale = 8'd8; majority_en = 1'b1; cyc(0, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int e = 0; e < 8; e++) begin
        cyc(e, 1'b1, 1'b1);
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL nominal ec=%0d got=%b exp=%b", e, obs, exp_vec); end
        n_vec++; if (v0 !== (e == 6)) begin n_err++; $display("FAIL nominal_valid ec=%0d got=%b exp=%b", e, v0, e == 6); end
        if (e == 6) begin
          n_vec++; if ({sd0, nz0} !== 2'b10) begin n_err++; $display("FAIL nominal_bit got=%b exp=10", {sd0, nz0}); end
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] pats [2];
    logic [1:0] want [2];
    pats[0] = 8'b1110_1111; want[0] = 2'b11;
    pats[1] = 8'b1110_0111; want[1] = 2'b01;
    prescale = 8'd8; majority_en = 1'b1; cyc(0, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < 8; e++) begin
        cyc(e, pats[p][e], 1'b1);
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL glitch p=%0d ec=%0d got=%b exp=%b", p, e, obs, exp_vec); end
        if (e == 6) begin
          n_vec++; if ({v0, sd0, nz0} !== {1'b1, want[p]}) begin n_err++; $display("FAIL glitch_bit p=%0d got=%b exp=%b", p, {v0, sd0, nz0}, {1'b1, want[p]}); end
        end
      end
    end
  endtask

  task automatic test_abort_enable();
    prescale = 8'd8; majority_en = 1'b1;
    for (int e = 0; e < 8; e++) begin
      cyc(e, 1'b1, e != 4);
      n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL abort_en ec=%0d got=%b exp=%b", e, obs, exp_vec); end
      n_vec++; if (v0 !== 1'b0) begin n_err++; $display("FAIL abort_en_valid ec=%0d got=%b exp=0", e, v0); end
    end
    n_vec++; if (sd0 !== 1'b0) begin n_err++; $display("FAIL abort_en_hold got=%b exp=0", sd0); end
  endtask

  task automatic test_abort_jump();
    int seq [13] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6, 7};
    prescale = 8'd8; majority_en = 1'b1; cyc(0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cyc(seq[i], 1'b1, 1'b1);
      n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL abort_jump i=%0d got=%b exp=%b", i, obs, exp_vec); end
      n_vec++; if (v0 !== (i == 11)) begin n_err++; $display("FAIL abort_jump_valid i=%0d got=%b exp=%b", i, v0, i == 11); end
    end
  endtask

  task automatic test_single();
    logic [7:0] pat = 8'b1110_1111;
    prescale = 8'd8; majority_en = 1'b0; cyc(0, 1'b1, 1'b0);
    for (int e = 0; e < 8; e++) begin
      cyc(e, pat[e], 1'b1);
      n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL single ec=%0d got=%b exp=%b", e, obs, exp_vec); end
      n_vec++; if (v0 !== (e == 5)) begin n_err++; $display("FAIL single_valid ec=%0d got=%b exp=%b", e, v0, e == 5); end
      if (e == 5) begin
        n_vec++; if ({sd0, nz0} !== 2'b00) begin n_err++; $display("FAIL single_bit got=%b exp=00", {sd0, nz0}); end
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] pat4 = 4'b1011;
    logic [4:0] pat5 = 5'b11101;
    prescale = 8'd4; majority_en = 1'b1; cyc(0, 1'b1, 1'b0);
    for (int e = 0; e < 4; e++) begin
      cyc(e, pat4[e], 1'b1);
      n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL cfg4 ec=%0d got=%b exp=%b", e, obs, exp_vec); end
      n_vec++; if ({cfg0, v0} !== {1'b1, e == 3}) begin n_err++; $display("FAIL cfg4_flags ec=%0d got=%b exp=%b", e, {cfg0, v0}, {1'b1, e == 3}); end
    end
    n_vec++; if ({sd0, nz0} !== 2'b00) begin n_err++; $display("FAIL cfg4_bit got=%b exp=00", {sd0, nz0}); end
    prescale = 8'd5; cyc(0, 1'b1, 1'b0);
    for (int e = 0; e < 5; e++) begin
      cyc(e, pat5[e], 1'b1);
      n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL cfg5 ec=%0d got=%b exp=%b", e, obs, exp_vec); end
      n_vec++; if ({cfg0, v0} !== {1'b0, e == 4}) begin n_err++; $display("FAIL cfg5_flags ec=%0d got=%b exp=%b", e, {cfg0, v0}, {1'b0, e == 4}); end
    end
    n_vec++; if ({sd0, nz0} !== 2'b11) begin n_err++; $display("FAIL cfg5_bit got=%b exp=11", {sd0, nz0}); end
  endtask

  task automatic test_sync();
    prescale = 8'd8; majority_en = 1'b1; cyc(0, 1'b1, 1'b0);
    for (int e = 0; e < 8; e++) begin
      cyc(e, e < 2, 1'b1);
      n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL sync ec=%0d got=%b exp=%b", e, obs, exp_vec); end
      if (e == 6) begin
        n_vec++; if ({v2, sd2, nz2} !== 3'b101) begin n_err++; $display("FAIL sync2_bit got=%b exp=101", {v2, sd2, nz2}); end
        n_vec++; if ({v0, sd0, nz0} !== 3'b100) begin n_err++; $display("FAIL sync0_bit got=%b exp=100", {v0, sd0, nz0}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat = 8'b1110_0111;
    prescale = 8'd8; majority_en = 1'b1; cyc(0, 1'b1, 1'b0);
    for (int e = 0; e < 8; e++) cyc(e, pat[e], 1'b1);
    n_vec++; if ({sd0, nz0} !== 2'b01) begin n_err++; $display("FAIL reset_mid_pre got=%b exp=01", {sd0, nz0}); end
    for (int e = 0; e < 5; e++) cyc(e, 1'b1, 1'b1);
    #3 rst = 1'b0; model_reset();
    #1;
    n_vec++; if (obs !== 8'b0100_0100) begin n_err++; $display("FAIL reset_mid got=%b exp=%b", obs, 8'b0100_0100); end
    n_vec++; if (st0 !== ST_IDLE) begin n_err++; $display("FAIL reset_mid_state got=%0d exp=%0d", st0, ST_IDLE); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_random();
    int ec, nvalid;
    bit prev_v;
    nvalid = 0; prev_v = 1'b0;
    for (int p = 0; p < 150; p++) begin
      prescale    = 8'($urandom_range(1, 12));
      majority_en = 1'($urandom_range(0, 1));
      ec = 0;
      for (int k = 0; k < int'(prescale); k++) begin
        if ($urandom_range(0, 24) == 0) ec = $urandom_range(0, int'(prescale) - 1);
        cyc(ec, 1'($urandom_range(0, 1)), $urandom_range(0, 19) != 0);
        n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL random p=%0d ec=%0d got=%b exp=%b", p, ec, obs, exp_vec); end
        n_vec++; if (v0 && prev_v) begin n_err++; $display("FAIL random_double_valid p=%0d got=11 exp=not 11", p); end
        prev_v = v0;
        if (v0) nvalid++;
        ec = (ec + 1) % int'(prescale);
      end
    end
    n_vec++; if (nvalid == 0) begin n_err++; $display("FAIL random_activity got=0 exp=>0 valids"); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_glitch();
    test_abort_enable();
    test_abort_jump();
    test_single();
    test_cfg_err();
    test_sync();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
